// File: rtl/regbank_pkg.sv
// Shared register-bank definitions: register count, address width and the
// hardwired zero register used by the writeback scheduler.
package regbank_pkg;

    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr (wrapping)
// and reports the pointer value that follows that grant.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] next_ptr
);

    logic [PW-1:0] idx_s;
    logic          found_s;

    // Scan requesters starting at ptr; the first active one wins.
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found_s  = 1'b0;
        idx_s    = '0;
        for (int i = 0; i < N; i++) begin
            idx_s = PW'((int'(ptr) + i) % N);
            if (!found_s && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                next_ptr     = PW'((int'(idx_s) + 1) % N);
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/regbank_wb_sched.sv
// Register-bank write-port scheduler: arbitrates writeback sources onto the
// single write port and keeps a busy scoreboard for RAW/WAW hazard detection.
module regbank_wb_sched #(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int NREG = regbank_pkg::NREG
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     issue_valid,
    input  regbank_pkg::reg_addr_t                   issue_rd,
    output logic                                     issue_stall,
    input  regbank_pkg::reg_addr_t                   rs1,
    input  regbank_pkg::reg_addr_t                   rs2,
    output logic                                     hazard1,
    output logic                                     hazard2,
    input  logic [NREQ-1:0]                          wb_valid,
    input  logic [NREQ-1:0][regbank_pkg::REG_AW-1:0] wb_rd,
    input  logic [NREQ-1:0][XLEN-1:0]                wb_data,
    output logic [NREQ-1:0]                          wb_ready,
    output logic                                     wreg,
    output regbank_pkg::reg_addr_t                   write_reg,
    output logic [XLEN-1:0]                          write_data,
    output logic                                     wb_err
);

    import regbank_pkg::*;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;
    logic [PW-1:0]   ptr_r;
    logic [PW-1:0]   next_ptr_s;
    logic [NREQ-1:0] grant_s;
    logic            xfer_s;
    reg_addr_t       sel_rd_s;
    logic [XLEN-1:0] sel_data_s;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
        .req      (wb_valid),
        .ptr      (ptr_r),
        .grant    (grant_s),
        .next_ptr (next_ptr_s)
    );

    assign wb_ready = grant_s;
    assign xfer_s   = |grant_s;

    // Mux the granted requester's destination and data.
    always_comb begin
        sel_rd_s   = REG_ZERO;
        sel_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_s[i]) begin
                sel_rd_s   = wb_rd[i];
                sel_data_s = wb_data[i];
            end else begin
                sel_rd_s   = sel_rd_s;
            end
        end
    end

    // Registered busy only: a clear is never bypassed to a same-cycle issue.
    assign issue_stall = issue_valid && busy_r[issue_rd];

    // The wreg term covers the cycle where the value is still in flight to the bank.
    assign hazard1 = (rs1 != REG_ZERO) && (busy_r[rs1] || (wreg && (write_reg == rs1)));
    assign hazard2 = (rs2 != REG_ZERO) && (busy_r[rs2] || (wreg && (write_reg == rs2)));

    // Scoreboard next state: set on accepted issue, clear on accepted writeback.
    always_comb begin
        busy_nxt_s = busy_r;
        if (issue_valid && !issue_stall && (issue_rd != REG_ZERO)) begin
            busy_nxt_s[issue_rd] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (xfer_s && (sel_rd_s != REG_ZERO)) begin
            busy_nxt_s[sel_rd_s] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Scoreboard and round-robin pointer state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_r <= '0;
            ptr_r  <= '0;
        end else begin
            busy_r <= busy_nxt_s;
            ptr_r  <= next_ptr_s;
        end
    end

    // Write-port output register and sticky error flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wreg       <= 1'b0;
            write_reg  <= REG_ZERO;
            write_data <= '0;
            wb_err     <= 1'b0;
        end else begin
            wreg   <= xfer_s && (sel_rd_s != REG_ZERO);
            wb_err <= wb_err || (xfer_s && (sel_rd_s != REG_ZERO) && !busy_r[sel_rd_s]);
            if (xfer_s && (sel_rd_s != REG_ZERO)) begin
                write_reg  <= sel_rd_s;
                write_data <= sel_data_s;
            end else begin
                write_reg  <= write_reg;
                write_data <= write_data;
            end
        end
    end

endmodule
